// File: rtl/tick_rate_controller_pkg.sv
// Shared definitions for the tick rate controller: FSM encoding and reset division value.
package tick_rate_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam int unsigned TRC_DEFAULT_DIV = 20400;

endpackage

// File: rtl/tick_rate_controller_tick_counter.sv
// Period counter cycling 1..active_div; tc flags the terminal count of the current period.
module tick_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] active_div,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count;

  // The >= compare keeps the count inside 1..active_div even if the divisor shrinks.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count >= active_div) begin
      count <= ONE;
    end else begin
      count <= count + ONE;
    end
  end

  assign tc = (count == active_div);

endmodule

// File: rtl/tick_rate_controller.sv
// Programmable tick generator with valid/ready divisor update that switches only at a period boundary.
module tick_rate_controller
  import tick_rate_controller_pkg::*;
#(
  parameter int          CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = TRC_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             divided_clk,
  output logic [CNT_W-1:0] active_div,
  output logic             busy,
  output state_t           state
);

  // cfg handshake: a transfer happens in any cycle where cfg_valid && cfg_ready;
  // cfg_div is sampled in that cycle. cfg_ready depends only on state, never on cfg_valid.

  state_t           state_next;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] active_next;
  logic             load_active;
  logic             load_pending;
  logic             hs;
  logic             div_ok;
  logic             tc;
  logic             tick_next;

  assign cfg_ready = (state != PENDING);
  assign busy      = (state != IDLE);
  assign hs        = cfg_valid && cfg_ready;
  assign div_ok    = (cfg_div != '0);

  tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_next == IDLE),
    .active_div (active_div),
    .tc         (tc)
  );

  always_comb begin
    state_next   = state;
    active_next  = active_div;
    load_active  = 1'b0;
    load_pending = 1'b0;
    case (state)
      IDLE: begin
        if (hs && div_ok) begin
          active_next = cfg_div;
          load_active = 1'b1;
        end else if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
          if (hs && div_ok) begin
            active_next = cfg_div;
            load_active = 1'b1;
          end
        end else if (hs && div_ok) begin
          state_next   = PENDING;
          load_pending = 1'b1;
        end
      end
      PENDING: begin
        // Swapping at the terminal count makes the next period the first at the new rate.
        if (!en || tc) begin
          state_next  = en ? RUN : IDLE;
          active_next = pending;
          load_active = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tick_next = tc && (state != IDLE) && (state_next != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_div  <= CNT_W'(DEFAULT_DIV);
      pending     <= '0;
      tick        <= 1'b0;
      divided_clk <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state <= state_next;
      if (load_active) begin
        active_div <= active_next;
      end
      if (load_pending) begin
        pending <= cfg_div;
      end
      tick        <= tick_next;
      divided_clk <= (state_next == IDLE) ? 1'b0 : (divided_clk ^ tick_next);
      cfg_err     <= hs && !div_ok;
    end
  end

endmodule

// File: tb/tb_tick_rate_controller.sv
// Directed bench for tick_rate_controller: vector table plus default-divisor period sequence.
module tb_tick_rate_controller;
  import tick_rate_controller_pkg::*;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tick;
  logic             divided_clk;
  logic [CNT_W-1:0] active_div;
  logic             busy;
  state_t           state;

  int checks = 0;
  int errors = 0;

  tick_rate_controller #(.CNT_W(CNT_W), .DEFAULT_DIV(20400)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .tick        (tick),
    .divided_clk (divided_clk),
    .active_div  (active_div),
    .busy        (busy),
    .state       (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             en;
    logic             cv;
    logic [CNT_W-1:0] div;
    state_t           st;
    logic             tick;
    logic             dclk;
    logic             err;
    logic [CNT_W-1:0] act;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic v, input int d,
                     input state_t s, input logic t, input logic dc, input logic er,
                     input int a);
    vec_t x;
    x.rst = r; x.en = e; x.cv = v; x.div = CNT_W'(d);
    x.st = s; x.tick = t; x.dclk = dc; x.err = er; x.act = CNT_W'(a);
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // driver: inputs already applied, clock once, settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic v, input logic [CNT_W-1:0] d);
    rst = r; en = e; cfg_valid = v; cfg_div = d;
  endtask

  initial begin
    int cnt;
    drive(1'b1, 1'b0, 1'b0, '0);

    //   rst en cv div   state    tick dclk err active
    add(1, 0, 0, 0,    IDLE,    0, 0, 0, 20400); // reset
    add(0, 0, 1, 4,    IDLE,    0, 0, 0, 4);     // config in IDLE
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 4);     // RUN cycle 0
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 4);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 4);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 4);
    add(0, 1, 0, 0,    RUN,     1, 1, 0, 4);     // tick at RUN cycle 4
    add(0, 1, 0, 0,    RUN,     0, 1, 0, 4);
    add(0, 1, 0, 0,    RUN,     0, 1, 0, 4);
    add(0, 1, 0, 0,    RUN,     0, 1, 0, 4);
    add(0, 1, 0, 0,    RUN,     1, 0, 0, 4);     // tick at 8
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 4);     // count 2
    add(0, 1, 1, 2,    PENDING, 0, 0, 0, 4);     // offer 2 at count 2
    add(0, 1, 0, 0,    PENDING, 0, 0, 0, 4);
    add(0, 1, 0, 0,    RUN,     1, 1, 0, 2);     // tick at 12, switch
    add(0, 1, 0, 0,    RUN,     0, 1, 0, 2);
    add(0, 1, 0, 0,    RUN,     1, 0, 0, 2);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 2);
    add(0, 1, 0, 0,    RUN,     1, 1, 0, 2);
    add(0, 1, 1, 0,    RUN,     0, 1, 1, 2);     // zero divisor rejected
    add(0, 1, 0, 0,    RUN,     1, 0, 0, 2);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 2);     // terminal-count cycle
    add(0, 1, 1, 6,    PENDING, 1, 1, 0, 2);     // offer 6 at terminal count
    add(0, 1, 0, 0,    PENDING, 0, 1, 0, 2);
    add(0, 1, 0, 0,    RUN,     1, 0, 0, 6);     // applied at following tc
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, RUN, 0, 0, 0, 6);
    add(0, 1, 0, 0,    RUN,     1, 1, 0, 6);     // 6-cycle period
    add(0, 1, 1, 3,    PENDING, 0, 1, 0, 6);
    add(0, 1, 1, 5,    PENDING, 0, 1, 0, 6);     // ignored: not ready
    add(0, 0, 0, 0,    IDLE,    0, 0, 0, 3);     // en drop in PENDING
    add(0, 0, 1, 4,    IDLE,    0, 0, 0, 4);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 4);
    add(0, 1, 1, 9,    PENDING, 0, 0, 0, 4);     // pending 9
    add(1, 1, 1, 7,    IDLE,    0, 0, 0, 20400); // reset wins
    add(0, 0, 0, 0,    IDLE,    0, 0, 0, 20400);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 20400);
    add(0, 0, 0, 0,    IDLE,    0, 0, 0, 20400); // pending discarded
    add(0, 0, 1, 3,    IDLE,    0, 0, 0, 3);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 3);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 3);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 3);     // terminal count
    add(0, 0, 0, 0,    IDLE,    0, 0, 0, 3);     // no tick entering IDLE
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 3);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 3);
    add(0, 1, 0, 0,    RUN,     0, 0, 0, 3);
    add(0, 1, 0, 0,    RUN,     1, 1, 0, 3);     // restart from zero

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].cv, vecs[i].div);
      step();
      check("state",       i, 32'(state),       32'(vecs[i].st));
      check("tick",        i, 32'(tick),        32'(vecs[i].tick));
      check("divided_clk", i, 32'(divided_clk), 32'(vecs[i].dclk));
      check("cfg_err",     i, 32'(cfg_err),     32'(vecs[i].err));
      check("active_div",  i, 32'(active_div),  32'(vecs[i].act));
      check("cfg_ready",   i, 32'(cfg_ready),   32'(vecs[i].st != PENDING));
      check("busy",        i, 32'(busy),        32'(vecs[i].st != IDLE));
    end

    // default divisor: first tick 20400 cycles after RUN entry, then every 20400
    drive(1'b1, 1'b0, 1'b0, '0);
    step();
    drive(1'b0, 1'b1, 1'b0, '0);
    step();
    check("dflt_run_entry", 0, 32'(state), 32'(RUN));
    cnt = 0;
    while (!tick && cnt < 25000) begin
      step();
      cnt++;
    end
    check("dflt_first_tick", 0, 32'(cnt), 32'd20400);
    check("dflt_dclk_high", 0, 32'(divided_clk), 32'd1);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick && cnt < 25000);
    check("dflt_period", 0, 32'(cnt), 32'd20400);
    check("dflt_dclk_low", 0, 32'(divided_clk), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
